// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use detection
module id_ex_stage #(
  parameter logic [3:0] NOP_CTR = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [3:0]  id_alu_ctr,
  input  logic        id_alu_src,
  input  logic        id_sign_ext,
  input  logic        id_shamt_sel,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_input1,
  output logic [31:0] alu_input2,
  output logic [3:0]  alu_ctr,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_valid,
  output logic        load_use
);
  logic [4:0]  rs, rt, shamt;
  logic [31:0] rs_data, rt_data, fwd_rs, fwd_rt, ext_imm;
  logic [15:0] imm;
  logic [3:0]  op;
  logic        alu_src, sign_ext, shamt_sel, is_shift;
  always_ff @(posedge clk)
    if (reset || flush || (!stall && !id_valid)) begin
      ex_valid      <= 1'b0;
      rs            <= '0;
      rt            <= '0;
      ex_rd         <= '0;
      rs_data       <= '0;
      rt_data       <= '0;
      imm           <= '0;
      shamt         <= '0;
      op            <= NOP_CTR;
      alu_src       <= 1'b0;
      sign_ext      <= 1'b0;
      shamt_sel     <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (stall) begin
      // refresh operands so a producer retiring during the stall is not lost
      rs_data <= fwd_rs;
      rt_data <= fwd_rt;
    end else begin
      ex_valid      <= 1'b1;
      rs            <= id_rs;
      rt            <= id_rt;
      ex_rd         <= id_rd;
      rs_data       <= id_rs_data;
      rt_data       <= id_rt_data;
      imm           <= id_imm;
      shamt         <= id_shamt;
      op            <= id_alu_ctr;
      alu_src       <= id_alu_src;
      sign_ext      <= id_sign_ext;
      shamt_sel     <= id_shamt_sel;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
    end
  assign fwd_rs = (exmem_reg_write && exmem_rd == rs && rs != 5'd0) ? exmem_result :
                  (memwb_reg_write && memwb_rd == rs && rs != 5'd0) ? memwb_result : rs_data;
  assign fwd_rt = (exmem_reg_write && exmem_rd == rt && rt != 5'd0) ? exmem_result :
                  (memwb_reg_write && memwb_rd == rt && rt != 5'd0) ? memwb_result : rt_data;
  assign ext_imm  = sign_ext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  assign is_shift = op == 4'b1000 || op == 4'b1010 || op == 4'b1011;
  assign alu_input1 = !is_shift ? fwd_rs : shamt_sel ? {27'b0, shamt} : {27'b0, fwd_rs[4:0]};
  assign alu_input2 = alu_src ? ext_imm : fwd_rt;
  assign alu_ctr = op;
  assign ex_store_data = fwd_rt;
  assign load_use = ex_valid && ex_mem_read && ex_rd != 5'd0 && id_valid &&
                    (ex_rd == id_rs || ex_rd == id_rt);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plan checks plus randomized traffic against an instruction-level model
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [3:0]  id_alu_ctr;
  logic        id_alu_src, id_sign_ext, id_shamt_sel;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_input1, alu_input2, ex_store_data;
  logic [3:0]  alu_ctr;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, load_use;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src),
    .id_sign_ext(id_sign_ext), .id_shamt_sel(id_shamt_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_ctr(alu_ctr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_valid(ex_valid), .load_use(load_use)
  );

  // the instruction currently sitting in EX, as the spec describes it
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic [3:0]  op;
    logic        src, sx, ssel, rw, mr, mw, m2r;
  } ex_t;
  ex_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ex_t bubble();
    ex_t b = '0;
    b.op = 4'b0001;
    return b;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] stored);
    if (idx == 0) return stored;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return stored;
  endfunction

  task automatic check_all();
    logic [31:0] a, b, ext, in1;
    a   = fwd(m.rs, m.a);
    b   = fwd(m.rt, m.b);
    ext = m.sx ? {{16{m.imm[15]}}, m.imm} : {16'b0, m.imm};
    in1 = (m.op inside {4'b1000, 4'b1010, 4'b1011}) ? (m.ssel ? 32'(m.sh) : 32'(a[4:0])) : a;
    check("in1", alu_input1, in1);
    check("in2", alu_input2, m.src ? ext : b);
    check("ctr", 32'(alu_ctr), 32'(m.op));
    check("store", ex_store_data, b);
    check("rd", 32'(ex_rd), 32'(m.rd));
    check("ctl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
          32'({m.v, m.rw, m.mr, m.mw, m.m2r}));
    check("load_use", 32'(load_use),
          32'(m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt)));
  endtask

  task automatic step();
    ex_t n;
    if (reset || flush) n = bubble();
    else if (stall) begin
      n = m;
      n.a = fwd(m.rs, m.a);
      n.b = fwd(m.rt, m.b);
    end else if (!id_valid) n = bubble();
    else begin
      n.v = 1'b1; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd; n.sh = id_shamt;
      n.a = id_rs_data; n.b = id_rt_data; n.imm = id_imm; n.op = id_alu_ctr;
      n.src = id_alu_src; n.sx = id_sign_ext; n.ssel = id_shamt_sel;
      n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write; n.m2r = id_mem_to_reg;
    end
    @(posedge clk);
    #1 m = n;
  endtask

  task automatic clr();
    {reset, stall, flush, id_valid} = '0;
    {id_rs, id_rt, id_rd, id_shamt, id_rs_data, id_rt_data, id_imm, id_alu_ctr} = '0;
    {id_alu_src, id_sign_ext, id_shamt_sel, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = '0;
    {exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result} = '0;
  endtask

  task automatic ld(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                    input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                    input logic [4:0] sh, input logic [3:0] op,
                    input logic src, input logic sx, input logic ssel, input logic mr);
    clr();
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b;
    id_imm = imm; id_shamt = sh; id_alu_ctr = op; id_alu_src = src; id_sign_ext = sx;
    id_shamt_sel = ssel; id_reg_write = 1'b1; id_mem_read = mr; id_mem_to_reg = mr;
    step();
    clr();
    #1;
  endtask

  initial begin
    m = bubble();
    clr();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_ctr", 32'(alu_ctr), 32'h1);
    check("rst_in1", alu_input1, 32'h0);
    check("rst_in2", alu_input2, 32'h0);
    check("rst_ctl", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'h0);
    check("rst_lu", 32'(load_use), 32'h0);
    check_all();

    ld(1, 2, 3, 5, 7, 0, 0, 4'b0001, 0, 0, 0, 0);
    check("add_in1", alu_input1, 32'd5);
    check("add_in2", alu_input2, 32'd7);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_rw", 32'(ex_reg_write), 32'd1);
    check_all();

    ld(4, 0, 9, 32'h11, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'hBB;
    #1 check("fwd_ex", alu_input1, 32'hAA);
    exmem_reg_write = 0;
    #1 check("fwd_wb", alu_input1, 32'hBB);
    check_all();
    ld(0, 0, 9, 32'h55, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
    #1 check("fwd_r0", alu_input1, 32'h55);
    check_all();

    ld(1, 2, 3, 0, 32'h80000000, 0, 3, 4'b1011, 0, 0, 1, 0);
    check("sra_in1", alu_input1, 32'd3);
    check("sra_in2", alu_input2, 32'h80000000);
    check("sra_ctr", 32'(alu_ctr), 32'hB);
    ld(1, 2, 3, 32'h124, 0, 0, 0, 4'b1011, 0, 0, 0, 0);
    check("srav_in1", alu_input1, 32'd4);
    ld(0, 3, 3, 0, 0, 16'h8001, 0, 4'b1001, 1, 0, 0, 0);
    check("lui_in2", alu_input2, 32'h00008001);
    check("lui_ctr", 32'(alu_ctr), 32'h9);
    ld(1, 3, 3, 0, 0, 16'hFFFF, 0, 4'b0001, 1, 1, 0, 0);
    check("addi_in2", alu_input2, 32'hFFFFFFFF);
    check_all();

    ld(1, 0, 5, 0, 0, 0, 0, 4'b0001, 1, 1, 0, 1);
    id_valid = 1; id_rs = 5;
    #1 check("load_use", 32'(load_use), 32'd1);
    check_all();

    ld(1, 6, 7, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    stall = 1; memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h1234;
    #1 check("stall_fwd", alu_input2, 32'h1234);
    step();
    step();
    memwb_reg_write = 0;
    #1 check("stall_hold", alu_input2, 32'h1234);
    check_all();
    flush = 1;
    step();
    check("sf_valid", 32'(ex_valid), 32'd0);
    check("sf_ctr", 32'(alu_ctr), 32'h1);
    check_all();
    ld(1, 2, 3, 9, 9, 0, 0, 4'b0010, 0, 0, 0, 1);
    stall = 1; reset = 1;
    step();
    check("rst_stall", 32'({ex_valid, ex_mem_read, ex_rd}), 32'h0);
    check_all();

    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 49) == 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 4) == 0;
      id_valid = $urandom_range(0, 7) != 0;
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7)); id_shamt = 5'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_alu_ctr = 4'($urandom); id_alu_src = 1'($urandom); id_sign_ext = 1'($urandom);
      id_shamt_sel = 1'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
      id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
      #1 check_all();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
